// File: rtl/input_conditioner.sv
// input_conditioner: synchronizes and debounces four active-low push-buttons
// and ten slide switches, then derives press pulses, a switch-change pulse and
// optional sticky press flags.
//
// Build option: define INPUT_COND_EDGE_CAPTURE_EN to build the sticky
// edge_capture flags with their write-1-to-clear edge_clear strobes. When the
// macro is undefined, edge_capture is tied to zero and edge_clear is ignored.

module input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic [3:0] key_raw,
  input  logic [9:0] sw_raw,
  input  logic [3:0] edge_clear,
  output logic [3:0] button_export,
  output logic [9:0] switch_export,
  output logic [3:0] key_press,
  output logic       sw_change,
  output logic [3:0] edge_capture
);

  localparam int unsigned KEY_W  = 4;
  localparam int unsigned SW_W   = 10;
  localparam int unsigned NBITS  = KEY_W + SW_W;
  localparam int unsigned CNT_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  // Keys idle high (released), switches idle low.
  localparam logic [NBITS-1:0] RST_VAL  = {{SW_W{1'b0}}, {KEY_W{1'b1}}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Bit layout of all per-bit vectors: [KEY_W-1:0] keys, [NBITS-1:KEY_W] switches.
  logic [NBITS-1:0] raw_all;
  logic [NBITS-1:0] sync1_q;
  logic [NBITS-1:0] sync2_q;
  logic [NBITS-1:0] deb_q;
  logic [NBITS-1:0] deb_d;
  logic [NBITS-1:0] deb_prev_q;
  logic [CNT_W-1:0] cnt_q [NBITS];
  logic [CNT_W-1:0] cnt_d [NBITS];

  assign raw_all = {sw_raw, key_raw};

  // Two-flop synchronizer: the only logic that samples the raw pins.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sync1_q <= RST_VAL;
      sync2_q <= RST_VAL;
    end else begin
      sync1_q <= raw_all;
      sync2_q <= sync1_q;
    end
  end

  // Per-bit debounce: count consecutive disagreeing clocks, accept on the last one.
  always_comb begin
    deb_d = deb_q;
    for (int unsigned i = 0; i < NBITS; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          deb_d[i] = sync2_q[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Debounced levels, their one-clock-old copy, and the stability counters.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      deb_q      <= RST_VAL;
      deb_prev_q <= RST_VAL;
      for (int unsigned i = 0; i < NBITS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      for (int unsigned i = 0; i < NBITS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Pulses fire the clock after a debounced change, lasting exactly one clock.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      key_press <= '0;
      sw_change <= 1'b0;
    end else begin
      key_press <= deb_prev_q[KEY_W-1:0] & ~deb_q[KEY_W-1:0];
      sw_change <= |(deb_prev_q[NBITS-1:KEY_W] ^ deb_q[NBITS-1:KEY_W]);
    end
  end

  assign button_export = deb_q[KEY_W-1:0];
  assign switch_export = deb_q[NBITS-1:KEY_W];

`ifdef INPUT_COND_EDGE_CAPTURE_EN
  logic [KEY_W-1:0] capture_q;

  // Sticky press flags; a press in the same clock as a clear keeps the flag set.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      capture_q <= '0;
    end else begin
      capture_q <= (capture_q & ~edge_clear) | key_press;
    end
  end

  assign edge_capture = capture_q;
`else
  // Capture disabled: flags read as zero and the clear strobes go nowhere.
  logic unused_edge_clear;
  assign unused_edge_clear = &{1'b0, edge_clear};
  assign edge_capture      = '0;
`endif

endmodule
